// File: rtl/hft_uart_pkg.sv
// Shared definitions for the market-data UART framing blocks.
// The transmitter and the receiver both use the frame layout and the delimiters defined here.
package hft_uart_pkg;

    localparam logic [7:0] MD_START     = 8'hF0;
    localparam logic [7:0] MD_STOP      = 8'h0F;
    localparam int         MD_FRAME_LEN = 19;
    localparam logic [4:0] MD_LAST_IDX  = 5'(MD_FRAME_LEN - 1);

    // Decoder-side markers, kept here so both ends of the link use the same constants.
    localparam logic [7:0] DEC_START = 8'h80;
    localparam logic [7:0] DEC_STOP  = 8'h01;
    localparam logic [7:0] DEC_BUY   = 8'hF0;
    localparam logic [7:0] DEC_SELL  = 8'h0F;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] buyprice;
        logic [31:0] sellprice;
        logic [31:0] buyvol;
        logic [31:0] sellvol;
    } md_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } md_tx_state_e;

endpackage

// File: rtl/md_frame_tx.sv
// Market-data frame transmitter: turns one md_dv strobe into a 19-byte frame
// (START, ADDR, four 32-bit fields LSB byte first, STOP) handed byte by byte to uart_tx.
//
// Handshakes:
//   md_dv is a 1-cycle strobe accepted only while md_busy is low. When accepted, all
//   md_* fields are captured that cycle and md_busy rises on the next one. A strobe
//   that arrives while md_busy is high is dropped and reported by md_overrun one cycle later.
//   uart_tx_dv is a 1-cycle strobe issued only when uart_tx_active is low. uart_tx_data
//   holds that byte until the next strobe. Only a uart_tx_done that follows a strobe
//   advances to the next byte; a done seen anywhere else is ignored.
import hft_uart_pkg::*;

module md_frame_tx #(
    parameter logic [7:0] START_BYTE = MD_START,
    parameter logic [7:0] STOP_BYTE  = MD_STOP,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             md_dv,
    input  logic [7:0]       md_addr,
    input  logic [31:0]      md_buyprice,
    input  logic [31:0]      md_sellprice,
    input  logic [31:0]      md_buyvol,
    input  logic [31:0]      md_sellvol,
    output logic             md_busy,
    output logic             md_overrun,
    output logic             uart_tx_dv,
    output logic [7:0]       uart_tx_data,
    input  logic             uart_tx_active,
    input  logic             uart_tx_done,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic [1:0]       dbg_state
);

    md_tx_state_e     state_q, state_d;
    logic [4:0]       byte_idx_q, byte_idx_d;
    md_frame_t        frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [7:0]       cur_byte;

    // Byte mux: select the frame byte for the current position, 32-bit fields LSB first.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_q)
            5'd0:    cur_byte = START_BYTE;
            5'd1:    cur_byte = frame_q.addr;
            5'd2:    cur_byte = frame_q.buyprice[7:0];
            5'd3:    cur_byte = frame_q.buyprice[15:8];
            5'd4:    cur_byte = frame_q.buyprice[23:16];
            5'd5:    cur_byte = frame_q.buyprice[31:24];
            5'd6:    cur_byte = frame_q.sellprice[7:0];
            5'd7:    cur_byte = frame_q.sellprice[15:8];
            5'd8:    cur_byte = frame_q.sellprice[23:16];
            5'd9:    cur_byte = frame_q.sellprice[31:24];
            5'd10:   cur_byte = frame_q.buyvol[7:0];
            5'd11:   cur_byte = frame_q.buyvol[15:8];
            5'd12:   cur_byte = frame_q.buyvol[23:16];
            5'd13:   cur_byte = frame_q.buyvol[31:24];
            5'd14:   cur_byte = frame_q.sellvol[7:0];
            5'd15:   cur_byte = frame_q.sellvol[15:8];
            5'd16:   cur_byte = frame_q.sellvol[23:16];
            5'd17:   cur_byte = frame_q.sellvol[31:24];
            5'd18:   cur_byte = STOP_BYTE;
            default: cur_byte = 8'h00;
        endcase
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        frame_d       = frame_q;
        busy_d        = busy_q;
        tx_dv_d       = 1'b0;
        tx_data_d     = tx_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        // busy_q is high in every non-idle state, including the cycle of the final done.
        overrun_d     = md_dv && busy_q;

        case (state_q)
            ST_IDLE: begin
                if (md_dv) begin
                    frame_d.addr      = md_addr;
                    frame_d.buyprice  = md_buyprice;
                    frame_d.sellprice = md_sellprice;
                    frame_d.buyvol    = md_buyvol;
                    frame_d.sellvol   = md_sellvol;
                    byte_idx_d        = 5'd0;
                    busy_d            = 1'b1;
                    state_d           = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!uart_tx_active) begin
                    tx_dv_d   = 1'b1;
                    tx_data_d = cur_byte;
                    state_d   = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (uart_tx_done) begin
                    if (byte_idx_q < MD_LAST_IDX) begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        state_d    = ST_SEND;
                    end else begin
                        busy_d        = 1'b0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            byte_idx_q    <= 5'd0;
            frame_q       <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            frame_q       <= frame_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            tx_dv_q       <= tx_dv_d;
            tx_data_q     <= tx_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign md_busy      = busy_q;
    assign md_overrun   = overrun_q;
    assign uart_tx_dv   = tx_dv_q;
    assign uart_tx_data = tx_data_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_md_frame_tx.sv
// Bench for md_frame_tx: directed frame/handshake/overrun/reset/wrap scenarios and a
// randomized run, with a byte-queue model of the frame and a responding uart_tx stand-in.
module tb_md_frame_tx;
    import hft_uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic        md_dv = 1'b0;
    logic [7:0]  md_addr = '0;
    logic [31:0] md_buyprice = '0, md_sellprice = '0, md_buyvol = '0, md_sellvol = '0;
    logic        uart_tx_active = 1'b0, uart_tx_done = 1'b0;
    logic        md_busy, md_overrun, uart_tx_dv, frame_done;
    logic [7:0]  uart_tx_data;
    logic [15:0] frame_count;
    logic [1:0]  dbg_state;
    // second instance with a 2-bit counter, driven identically
    logic        w_busy, w_ovr, w_dv, w_fd;
    logic [7:0]  w_data;
    logic [1:0]  w_cnt, w_dbg;

    md_frame_tx dut (
        .clk(clk), .reset_n(reset_n), .md_dv(md_dv), .md_addr(md_addr),
        .md_buyprice(md_buyprice), .md_sellprice(md_sellprice),
        .md_buyvol(md_buyvol), .md_sellvol(md_sellvol),
        .md_busy(md_busy), .md_overrun(md_overrun),
        .uart_tx_dv(uart_tx_dv), .uart_tx_data(uart_tx_data),
        .uart_tx_active(uart_tx_active), .uart_tx_done(uart_tx_done),
        .frame_done(frame_done), .frame_count(frame_count), .dbg_state(dbg_state)
    );

    md_frame_tx #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .md_dv(md_dv), .md_addr(md_addr),
        .md_buyprice(md_buyprice), .md_sellprice(md_sellprice),
        .md_buyvol(md_buyvol), .md_sellvol(md_sellvol),
        .md_busy(w_busy), .md_overrun(w_ovr),
        .uart_tx_dv(w_dv), .uart_tx_data(w_data),
        .uart_tx_active(uart_tx_active), .uart_tx_done(uart_tx_done),
        .frame_done(w_fd), .frame_count(w_cnt), .dbg_state(w_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame layout straight from the byte map: START, ADDR, 4x 32-bit LSB first, STOP.
    function automatic void frame_bytes(input md_frame_t f, output logic [7:0] b [MD_FRAME_LEN]);
        logic [31:0] w [4];
        w[0] = f.buyprice; w[1] = f.sellprice; w[2] = f.buyvol; w[3] = f.sellvol;
        b[0] = MD_START;
        b[1] = f.addr;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++)
                b[2 + 4*k + i] = 8'(w[k] >> (8*i));
        b[MD_FRAME_LEN-1] = MD_STOP;
    endfunction

    function automatic md_frame_t rand_frame();
        md_frame_t f;
        f.addr = 8'($urandom); f.buyprice = $urandom; f.sellprice = $urandom;
        f.buyvol = $urandom; f.sellvol = $urandom;
        return f;
    endfunction

    // ---------------- behavioural model + scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         cap_cyc[$];
    bit  p_busy, p_ovr, p_fd;
    int  p_cnt;
    bit  m_owed, m_waiting, prev_dv;
    int  m_sent, owed_idle;
    logic [7:0] last_data;
    int  ovr_cnt = 0, fd_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            p_busy = 0; p_ovr = 0; p_fd = 0; p_cnt = 0;
            m_owed = 0; m_waiting = 0; prev_dv = 0; m_sent = 0; owed_idle = 0;
            last_data = 8'h00;
            chk("reset_outputs", 32'({md_busy, md_overrun, uart_tx_dv, uart_tx_data, frame_done, frame_count}), 32'd0);
        end else begin
            bit cur_busy;
            logic [7:0] b [MD_FRAME_LEN];
            md_frame_t f;
            // compare registered outputs against predictions from the previous cycle
            chk("md_busy", 32'(md_busy), 32'(p_busy));
            chk("md_overrun", 32'(md_overrun), 32'(p_ovr));
            chk("frame_done", 32'(frame_done), 32'(p_fd));
            chk("frame_count", 32'(frame_count), p_cnt & 32'hFFFF);
            chk("frame_count_w2", 32'(w_cnt), p_cnt & 32'h3);
            chk("w2_lockstep", 32'({w_busy, w_ovr, w_dv, w_data, w_fd, w_dbg}),
                32'({md_busy, md_overrun, uart_tx_dv, uart_tx_data, frame_done, dbg_state}));
            chk("dv_twice", 32'(prev_dv & uart_tx_dv), 32'd0);
            if (uart_tx_dv) begin
                chk("dv_owed", 32'(m_owed), 32'd1);
                if (m_owed && exp_q.size() > 0) chk("tx_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
                m_owed = 0; m_waiting = 1; last_data = uart_tx_data;
                cap_q.push_back(uart_tx_data); cap_cyc.push_back(cyc);
            end else begin
                chk("data_hold", 32'(uart_tx_data), 32'(last_data));
            end
            if (m_owed && !uart_tx_active) owed_idle++; else owed_idle = 0;
            if (owed_idle > 3) begin
                chk("strobe_timeout", 32'(owed_idle), 32'd3);
                owed_idle = 0;
            end
            if (md_overrun) ovr_cnt++;
            if (frame_done) fd_cnt++;
            // predict next cycle from inputs seen this cycle
            cur_busy = p_busy;
            p_ovr = md_dv && cur_busy;
            p_fd = 0;
            if (uart_tx_done && m_waiting) begin
                m_waiting = 0;
                m_sent++;
                if (m_sent == MD_FRAME_LEN) begin
                    p_fd = 1; p_cnt++; p_busy = 0;
                end else begin
                    m_owed = 1;
                end
            end
            if (md_dv && !cur_busy) begin
                f.addr = md_addr; f.buyprice = md_buyprice; f.sellprice = md_sellprice;
                f.buyvol = md_buyvol; f.sellvol = md_sellvol;
                frame_bytes(f, b);
                for (int i = 0; i < MD_FRAME_LEN; i++) exp_q.push_back(b[i]);
                p_busy = 1; m_owed = 1; m_sent = 0;
            end
            prev_dv = uart_tx_dv;
        end
    end

    // ---------------- uart_tx stand-in ----------------
    bit force_active = 0;
    bit rand_mode = 0;
    int u_cnt = 0, u_hold = 0;

    always @(posedge clk) begin
        #1;
        uart_tx_done = 1'b0;
        if (!reset_n) begin
            u_cnt = 0; u_hold = 0; uart_tx_active = force_active;
        end else if (force_active) begin
            uart_tx_active = 1'b1;
        end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
                uart_tx_done = 1'b1; uart_tx_active = 1'b0;
                if (rand_mode) u_hold = $urandom_range(0, 2);
            end
        end else if (u_hold > 0) begin
            uart_tx_active = 1'b1; u_hold--;
        end else begin
            uart_tx_active = 1'b0;
            if (uart_tx_dv) begin
                uart_tx_active = 1'b1;
                u_cnt = rand_mode ? $urandom_range(1, 6) : 2;
            end else if (rand_mode && !md_busy && $urandom_range(0, 9) == 0) begin
                uart_tx_done = 1'b1;   // stray done while idle
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic drive_frame(input md_frame_t f);
        md_addr = f.addr; md_buyprice = f.buyprice; md_sellprice = f.sellprice;
        md_buyvol = f.buyvol; md_sellvol = f.sellvol;
        md_dv = 1'b1;
        tick();
        md_dv = 1'b0;
        md_addr = 8'($urandom); md_buyprice = $urandom; md_sellprice = $urandom;
        md_buyvol = $urandom; md_sellvol = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (md_busy && k < budget) begin tick(); k++; end
        if (md_busy) chk("idle_timeout", 32'(md_busy), 32'd0);
    endtask

    task automatic wait_cap(input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin tick(); k++; end
        if (cap_q.size() < n) chk("cap_timeout", 32'(cap_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({md_busy, md_overrun, uart_tx_dv, uart_tx_data, frame_done, frame_count}), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic void clear_cap();
        cap_q.delete(); cap_cyc.delete();
    endfunction

    task automatic chk_frame(input string name, input int base, input md_frame_t f);
        logic [7:0] b [MD_FRAME_LEN];
        frame_bytes(f, b);
        for (int i = 0; i < MD_FRAME_LEN; i++)
            chk(name, (base + i < cap_q.size()) ? 32'(cap_q[base + i]) : 32'hFFFF_FFFF, 32'(b[i]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        md_frame_t fa, fb, fx;
        logic [7:0] lit [MD_FRAME_LEN];
        logic [1:0] wrap_exp [5];
        int t0, ovr0, fd0, k;

        lit = '{8'hF0, 8'h2A, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                8'hFF, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0F};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'({md_busy, uart_tx_dv, uart_tx_data, frame_count, dbg_state}), 32'd0);
        reset_n = 1'b1;
        tick();

        // known frame: exact bytes, START latency, one frame_done, count 1
        fa = '{addr: 8'h2A, buyprice: 32'h11223344, sellprice: 32'h55667788,
               buyvol: 32'h0000_00FF, sellvol: 32'hDEADBEEF};
        clear_cap(); fd0 = fd_cnt;
        t0 = cyc;
        drive_frame(fa);
        wait_idle(1000);
        tick();
        chk("frame_len", 32'(cap_q.size()), 32'd19);
        for (int i = 0; i < MD_FRAME_LEN; i++)
            chk("lit_byte", (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF, 32'(lit[i]));
        chk("start_latency", (cap_cyc.size() > 0) ? 32'(cap_cyc[0] - t0) : 32'hFFFF_FFFF, 32'd2);
        chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
        chk("count_1", 32'(frame_count), 32'd1);

        // back-to-back after a fresh reset: second md_dv the cycle after frame_done
        do_reset();
        clear_cap();
        fb = rand_frame();
        drive_frame(fa);
        k = 0;
        while (!frame_done && k < 1000) begin tick(); k++; end
        if (!frame_done) chk("fd_timeout", 32'(frame_done), 32'd1);
        tick();
        drive_frame(fb);
        wait_idle(1000);
        tick();
        chk("b2b_len", 32'(cap_q.size()), 32'd38);
        chk("b2b_start", (cap_q.size() > 19) ? 32'(cap_q[19]) : 32'hFFFF_FFFF, 32'h0000_00F0);
        chk_frame("b2b_frame2", 19, fb);
        chk("count_2", 32'(frame_count), 32'd2);

        // uart_tx busy for 50 cycles: no strobe until it goes idle
        clear_cap();
        force_active = 1;
        tick();
        fb = rand_frame();
        drive_frame(fb);
        repeat (50) tick();
        chk("no_dv_while_active", 32'(cap_q.size()), 32'd0);
        force_active = 0;
        wait_idle(1000);
        tick();
        chk_frame("held_frame", 0, fb);

        // overrun at byte 5: dropped, original data kept, busy until STOP
        clear_cap();
        ovr0 = ovr_cnt;
        fb = rand_frame();
        fx = rand_frame();
        drive_frame(fb);
        wait_cap(6, 500);
        drive_frame(fx);
        tick(); tick();
        chk("overrun_pulse", 32'(ovr_cnt - ovr0), 32'd1);
        chk("busy_after_overrun", 32'(md_busy), 32'd1);
        wait_idle(1000);
        tick();
        chk("overrun_len", 32'(cap_q.size()), 32'd19);
        chk_frame("overrun_frame", 0, fb);

        // reset at byte 9, then a complete fresh frame
        clear_cap();
        drive_frame(rand_frame());
        wait_cap(10, 500);
        do_reset();
        clear_cap();
        fb = rand_frame();
        drive_frame(fb);
        wait_idle(1000);
        tick();
        chk("post_reset_len", 32'(cap_q.size()), 32'd19);
        chk_frame("post_reset_frame", 0, fb);

        // counter wrap on the 2-bit instance
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive_frame(rand_frame());
            wait_idle(1000);
            tick();
            chk("wrap_count", 32'(w_cnt), 32'(wrap_exp[n]));
        end

        // randomized traffic: random gaps, overruns, uart delays, stray done pulses
        rand_mode = 1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 30)) tick();
            drive_frame(rand_frame());
        end
        wait_idle(2000);
        rand_mode = 0;
        repeat (20) tick();
        chk("all_bytes_sent", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
